simd_vector_feeder: RTL and testbench
=====================================

# simd_vector_feeder

Transmit-side framer for the SIMD vector MAC lane protocol. It accepts a vector-length command and a serial stream of signed element pairs (a, b), then packs them into NUM_LANES-wide beats. Each beat is driven with `valid_o`/`start_o`/`last_o` framing, and unused tail lanes are zero-padded. It sits directly upstream of `simd_vector_mac`, converting memory/DMA-style scalar streams into lane beats.

## Interface
- `NUM_LANES`, 4, lanes per beat.
- `ELEM_W`, 16, signed element width.
- `MAX_NUM_ELEM`, 64, maximum elements per vector.
- `LEN_W`, `$clog2(MAX_NUM_ELEM+1)`, command length width (7 at defaults).
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `cmd_valid_i`  in  1  length command valid.
- `cmd_len_i`  in  LEN_W  vector length in scalar elements.
- `cmd_ready_o`  out  1  command accepted when `cmd_valid_i && cmd_ready_o`.
- `elem_valid_i`  in  1  element pair valid.
- `elem_a_i`, `elem_b_i`  in  ELEM_W (signed) each  element pair.
- `elem_ready_o`  out  1  pair consumed when `elem_valid_i && elem_ready_o`.
- `valid_o`, `start_o`, `last_o`  out  1 each  beat framing, in the same sense as the `simd_vector_mac` inputs.
- `A`, `B`  out  `[NUM_LANES-1:0][ELEM_W-1:0]` (signed)  lane data; lane 0 holds the earliest element.
- `out_ready_i`  in  1  beat accepted when `valid_o && out_ready_i`. Tie high when feeding `simd_vector_mac`.

## Operation
- FSM has three states: IDLE, FILL, SEND.
- **IDLE**
  - `cmd_ready_o`=1.
  - On accept, latch `remaining` = min(`cmd_len_i`, MAX_NUM_ELEM) and set `first`=1.
  - Go to FILL. With a zero length, see Configuration.
- **FILL**
  - `elem_ready_o`=1.
  - Each accepted pair is written to lane `slot`; then `slot` increments and `remaining` decrements.
  - When `slot` reaches NUM_LANES, or `remaining` reaches 0, go to SEND.
  - Unwritten lanes are 0; lanes are cleared on entry to FILL.
- **SEND**
  - `valid_o`=1.
  - `start_o`=`first`.
  - `last_o`=(`remaining`==0).
  - `A`, `B`, `start_o` and `last_o` are held stable until `out_ready_i`.
  - On accept: clear `first` and `slot`. If `remaining`==0 go to IDLE, else go to FILL.
- Lengths above MAX_NUM_ELEM are clamped. Surplus stream elements are not consumed by this command.
- Beats per vector = ceil(len/NUM_LANES).
- `elem_ready_o`=0 and `cmd_ready_o`=0 outside their states. Commands and elements are never dropped.
- There is no overlap: the next vector's fill starts only after the last beat has been accepted.

## Timing
- After reset: state IDLE.
  - `cmd_ready_o`=1.
  - `valid_o`, `start_o`, `last_o`, `elem_ready_o` = 0.
  - `A`, `B` = 0.
  - `slot`, `remaining`, `first` = 0.
- All outputs are registered or decoded from registered state. No input-to-output combinational path.
- Command accepted in cycle T:
  - FILL (`elem_ready_o`=1) in T+1.
  - With continuous elements, beat k is valid NUM_LANES cycles after its fill starts.
  - Example: len=4 gives elements in T+1..T+4 and `valid_o` in T+5.
- `elem_valid_i` gaps stall FILL with no state change.
- `out_ready_i`=0 holds SEND indefinitely.
- Last beat accepted in cycle U: `cmd_ready_o`=1 in U+1.
- `rst` asserted in any state: all state is cleared at that edge and the outputs take their reset values in the next cycle. A partial vector is discarded and no `last_o` is emitted for it.

## Configuration
- `SIMD_FEEDER_ZERO_LEN_EN`
  - **Defined:** a `cmd_len_i`=0 command goes straight to SEND with all lanes zero, `start_o`=`last_o`=1. The downstream MAC therefore emits a result of 0.
  - **Undefined:** a zero-length command is accepted (one cycle of `cmd_ready_o`) and discarded. The FSM stays in IDLE and no beat is emitted.

## Test plan
- **Single full beat.** len=4, A pairs 1,2,3,4 with B=2 each, `out_ready_i`=1.
  - One beat: `start_o`=`last_o`=1, `A`={4,3,2,1}, `B`={2,2,2,2}.
  - MAC result 20.
- **Partial tail.** len=6, A=1..6, B=1.
  - Beat 1: `start_o`=1, `last_o`=0, `A`={4,3,2,1}.
  - Beat 2: `start_o`=0, `last_o`=1, `A`={0,0,6,5}, `B`={0,0,1,1}.
- **Backpressure and gaps.** len=8, `out_ready_i` low for 5 cycles on beat 1, `elem_valid_i` toggled 50%.
  - `A`, `B`, `start_o`, `last_o` stay stable while stalled.
  - `elem_ready_o`=0 during SEND.
  - Exactly 2 beats, no element lost.
- **Clamp.** len=100 with 100 elements offered.
  - Exactly 16 beats; `last_o` on beat 16.
  - Elements 65..100 stay unconsumed until the next command.
- **Zero length.** len=0.
  - With the macro: one all-zero beat with `start_o`=`last_o`=1.
  - Without it: no beat, and `cmd_ready_o`=1 again the next cycle.
- **Reset mid-vector.** len=12, `rst` pulsed after 5 elements.
  - Next cycle: `valid_o`=0 and `cmd_ready_o`=1.
  - A new len=4 vector then produces a correct single beat with `start_o`=`last_o`=1.

Source files
------------

// File: rtl/simd_vector_feeder.sv
// Packs a serial stream of signed (a,b) element pairs into NUM_LANES-wide framed beats.
// Optional macro SIMD_FEEDER_ZERO_LEN_EN: a zero-length command emits one all-zero start/last beat.
module simd_vector_feeder #(
    parameter int NUM_LANES    = 4,
    parameter int ELEM_W       = 16,
    parameter int MAX_NUM_ELEM = 64,
    parameter int LEN_W        = $clog2(MAX_NUM_ELEM + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cmd_valid_i,
    input  logic [LEN_W-1:0]                   cmd_len_i,
    output logic                               cmd_ready_o,
    input  logic                               elem_valid_i,
    input  logic signed [ELEM_W-1:0]           elem_a_i,
    input  logic signed [ELEM_W-1:0]           elem_b_i,
    output logic                               elem_ready_o,
    output logic                               valid_o,
    output logic                               start_o,
    output logic                               last_o,
    output logic [NUM_LANES-1:0][ELEM_W-1:0]   A,
    output logic [NUM_LANES-1:0][ELEM_W-1:0]   B,
    input  logic                               out_ready_i
);
    localparam int SLOT_W = $clog2(NUM_LANES + 1);

    typedef enum logic [1:0] {IDLE, FILL, SEND} state_t;

    state_t            state, state_nxt;
    logic [SLOT_W-1:0] slot;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  len_clamp;
    logic              first;
    logic              cmd_fire, elem_fire, out_fire, lane_clr;

    assign len_clamp = (cmd_len_i > LEN_W'(MAX_NUM_ELEM)) ? LEN_W'(MAX_NUM_ELEM) : cmd_len_i;

    assign cmd_ready_o  = (state == IDLE);
    assign elem_ready_o = (state == FILL);
    assign valid_o      = (state == SEND);
    assign start_o      = valid_o && first;
    assign last_o       = valid_o && (remaining == '0);

    assign cmd_fire  = cmd_valid_i && cmd_ready_o;
    assign elem_fire = elem_valid_i && elem_ready_o;
    assign out_fire  = valid_o && out_ready_i;

    always_comb begin
        state_nxt = state;
        lane_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_fire) begin
                    if (len_clamp != '0) begin
                        state_nxt = FILL;
                        lane_clr  = 1'b1;
                    end
`ifdef SIMD_FEEDER_ZERO_LEN_EN
                    else begin
                        state_nxt = SEND;
                        lane_clr  = 1'b1;
                    end
`else
                    else begin
                        state_nxt = IDLE;
                    end
`endif
                end
            end
            FILL: begin
                if (elem_fire && (slot == SLOT_W'(NUM_LANES - 1) || remaining == LEN_W'(1)))
                    state_nxt = SEND;
            end
            SEND: begin
                if (out_fire) begin
                    if (remaining == '0) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = FILL;
                        lane_clr  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            slot      <= '0;
            remaining <= '0;
            first     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (cmd_fire) begin
                    remaining <= len_clamp;
                    first     <= 1'b1;
                    slot      <= '0;
                end
                FILL: if (elem_fire) begin
                    slot      <= slot + SLOT_W'(1);
                    remaining <= remaining - LEN_W'(1);
                end
                SEND: if (out_fire) begin
                    first <= 1'b0;
                    slot  <= '0;
                end
                default: ;
            endcase
        end
    end

    // Lanes are zeroed on every FILL entry so a short tail beat is zero-padded.
    always_ff @(posedge clk) begin
        if (rst || lane_clr) begin
            A <= '0;
            B <= '0;
        end else if (elem_fire) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (slot == SLOT_W'(l)) begin
                    A[l] <= elem_a_i;
                    B[l] <= elem_b_i;
                end
            end
        end
    end
endmodule

// File: tb/tb_simd_vector_feeder.sv
// Directed bench for simd_vector_feeder with a queue-based beat model and per-cycle checker.
module tb_simd_vector_feeder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic [6:0]  cmd_len_i = '0;
    logic        cmd_ready_o;
    logic        elem_valid_i = 1'b0;
    logic [15:0] elem_a_i = '0, elem_b_i = '0;
    logic        elem_ready_o;
    logic        valid_o, start_o, last_o;
    logic [3:0][15:0] A, B;
    logic        out_ready_i = 1'b1;

    simd_vector_feeder dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_len_i(cmd_len_i), .cmd_ready_o(cmd_ready_o),
        .elem_valid_i(elem_valid_i), .elem_a_i(elem_a_i), .elem_b_i(elem_b_i),
        .elem_ready_o(elem_ready_o),
        .valid_o(valid_o), .start_o(start_o), .last_o(last_o), .A(A), .B(B),
        .out_ready_i(out_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        s;
        logic        l;
    } beat_t;

    int n_checks = 0, n_fail = 0;
    int cyc = 0;
    logic [15:0] src_a[$], src_b[$];
    beat_t exp_q[$];
    int n_consumed = 0, beats = 0, stall_left = 0, t_cmd = 0, t_rise = 0;
    bit gap_en = 0, flush_req = 0, e_fire = 0, phase = 0;
    bit prev_valid = 0, hold_prev = 0, chk_cready = 0;
    logic [63:0] last_A, last_B, s_A, s_B;
    logic s_s, s_l;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Expected beats: take the next min(len,64) queued elements, NUM_LANES per beat.
    task automatic model_cmd(input int len);
        int n, nb;
        beat_t bt;
        n = (len > 64) ? 64 : len;
        if (n == 0) begin
`ifdef SIMD_FEEDER_ZERO_LEN_EN
            bt.a = '0; bt.b = '0; bt.s = 1'b1; bt.l = 1'b1;
            exp_q.push_back(bt);
`endif
            return;
        end
        nb = (n + 3) / 4;
        for (int bi = 0; bi < nb; bi++) begin
            bt.a = '0; bt.b = '0;
            for (int l = 0; l < 4; l++)
                if (bi * 4 + l < n) begin
                    bt.a[l*16 +: 16] = src_a[bi*4 + l];
                    bt.b[l*16 +: 16] = src_b[bi*4 + l];
                end
            bt.s = (bi == 0);
            bt.l = (bi == nb - 1);
            exp_q.push_back(bt);
        end
    endtask

    // Element source: presents the queue head, pops on handshake.
    always begin
        @(negedge clk);
        if (e_fire) begin
            void'(src_a.pop_front());
            void'(src_b.pop_front());
            n_consumed++;
        end
        if (flush_req) begin
            src_a.delete(); src_b.delete();
            flush_req = 0;
        end
        phase = ~phase;
        elem_valid_i = (src_a.size() > 0) && (!gap_en || phase);
        elem_a_i = (src_a.size() > 0) ? src_a[0] : 16'h0;
        elem_b_i = (src_b.size() > 0) ? src_b[0] : 16'h0;
        #1;
        e_fire = elem_valid_i && elem_ready_o && !rst;
    end

    // Output sink and per-cycle checker.
    always begin
        beat_t e;
        @(negedge clk);
        if (valid_o && stall_left > 0) begin
            out_ready_i = 1'b0;
            stall_left--;
        end else out_ready_i = 1'b1;
        #1;
        if (chk_cready) begin
            chk("cmd_ready_after_last", 64'(cmd_ready_o), 64'd1);
            chk_cready = 0;
        end
        if (valid_o && hold_prev) begin
            chk("stall_A", A, s_A);
            chk("stall_B", B, s_B);
            chk("stall_start", 64'(start_o), 64'(s_s));
            chk("stall_last", 64'(last_o), 64'(s_l));
        end
        if (valid_o && elem_ready_o) chk("elem_ready_in_send", 64'(elem_ready_o), 64'd0);
        if (valid_o && !prev_valid) t_rise = cyc;
        prev_valid = valid_o;
        if (valid_o && out_ready_i && !rst) begin
            beats++;
            last_A = A; last_B = B;
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_beat: got A=%0h B=%0h required none", A, B);
            end else begin
                e = exp_q.pop_front();
                chk("beat_A", A, e.a);
                chk("beat_B", B, e.b);
                chk("beat_start", 64'(start_o), 64'(e.s));
                chk("beat_last", 64'(last_o), 64'(e.l));
            end
            if (last_o) chk_cready = 1;
        end
        hold_prev = valid_o && !out_ready_i;
        s_A = A; s_B = B; s_s = start_o; s_l = last_o;
    end

    task automatic load(input int a, input int b);
        src_a.push_back(16'(a));
        src_b.push_back(16'(b));
    endtask

    task automatic send_cmd(input int len);
        bit done = 0;
        @(negedge clk);
        cmd_valid_i = 1'b1;
        cmd_len_i = 7'(len);
        for (int k = 0; k < 200 && !done; k++) begin
            #1;
            if (cmd_ready_o) begin
                model_cmd(len);
                t_cmd = cyc;
                done = 1;
            end else @(negedge clk);
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL cmd_timeout: got cmd_ready_o=0 required 1");
        end
        @(negedge clk);
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        bit done = 0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge clk); #2;
            if (exp_q.size() == 0 && cmd_ready_o) done = 1;
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL done_timeout: got %0d beats pending required 0", exp_q.size());
        end
    endtask

    initial begin
        int base, sum;
        bit hit;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #2;
        chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
        chk("rst_ctrl", {61'd0, valid_o, start_o, last_o}, 64'd0);
        chk("rst_elem_ready", 64'(elem_ready_o), 64'd0);
        chk("rst_A", A, 64'd0);
        chk("rst_B", B, 64'd0);

        // Single full beat
        for (int i = 1; i <= 4; i++) load(i, 2);
        beats = 0;
        send_cmd(4);
        wait_done();
        chk("t1_beats", 64'(beats), 64'd1);
        chk("t1_latency", 64'(t_rise - t_cmd), 64'd5);
        chk("t1_A_lit", last_A, {16'd4, 16'd3, 16'd2, 16'd1});
        chk("t1_B_lit", last_B, {16'd2, 16'd2, 16'd2, 16'd2});
        sum = 0;
        for (int l = 0; l < 4; l++) sum += int'($signed(last_A[l*16 +: 16])) * int'($signed(last_B[l*16 +: 16]));
        chk("t1_mac", 64'(sum), 64'd20);

        // Partial tail
        for (int i = 1; i <= 6; i++) load(i, 1);
        beats = 0;
        send_cmd(6);
        wait_done();
        chk("t2_beats", 64'(beats), 64'd2);
        chk("t2_A_lit", last_A, {16'd0, 16'd0, 16'd6, 16'd5});
        chk("t2_B_lit", last_B, {16'd0, 16'd0, 16'd1, 16'd1});

        // Backpressure and gaps, with negative values
        for (int i = 0; i < 8; i++) load(i * 3 - 7, 5 - i);
        beats = 0; base = n_consumed;
        gap_en = 1; stall_left = 5;
        send_cmd(8);
        wait_done();
        gap_en = 0;
        chk("t3_beats", 64'(beats), 64'd2);
        chk("t3_consumed", 64'(n_consumed - base), 64'd8);

        // Clamp
        for (int i = 0; i < 100; i++) load(i + 100, i);
        beats = 0; base = n_consumed;
        send_cmd(100);
        wait_done();
        repeat (4) @(negedge clk);
        #2;
        chk("t4_beats", 64'(beats), 64'd16);
        chk("t4_consumed", 64'(n_consumed - base), 64'd64);
        chk("t4_left", 64'(src_a.size()), 64'd36);
        beats = 0;
        send_cmd(36);
        wait_done();
        chk("t4b_beats", 64'(beats), 64'd9);
        chk("t4b_left", 64'(src_a.size()), 64'd0);

        // Zero length
        beats = 0;
        send_cmd(0);
        #2;
`ifndef SIMD_FEEDER_ZERO_LEN_EN
        chk("t5_cmd_ready_next", 64'(cmd_ready_o), 64'd1);
`endif
        wait_done();
        repeat (3) @(negedge clk);
`ifdef SIMD_FEEDER_ZERO_LEN_EN
        chk("t5_beats", 64'(beats), 64'd1);
        chk("t5_A", last_A, 64'd0);
`else
        chk("t5_beats", 64'(beats), 64'd0);
`endif

        // Reset mid-vector
        for (int i = 0; i < 12; i++) load(i + 1, -i);
        base = n_consumed;
        send_cmd(12);
        hit = 0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(negedge clk);
            if (n_consumed - base >= 5) hit = 1;
        end
        if (!hit) begin
            n_checks++; n_fail++;
            $display("FAIL t6_consume_timeout: got %0d required 5", n_consumed - base);
        end
        rst = 1'b1; flush_req = 1; exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("t6_valid_after_rst", 64'(valid_o), 64'd0);
        chk("t6_cmd_ready_after_rst", 64'(cmd_ready_o), 64'd1);
        chk("t6_A_after_rst", A, 64'd0);
        load(-1, 3); load(-2, -4); load(3, 5); load(4, 6);
        beats = 0;
        send_cmd(4);
        wait_done();
        chk("t6_beats", 64'(beats), 64'd1);
        chk("t6_A_lit", last_A, {16'd4, 16'd3, 16'hfffe, 16'hffff});

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog expired");
    end
endmodule
